// File: rtl/sync_ram_sp.sv
// sync_ram_sp: single-port synchronous RAM with registered read.
// Reset clears the whole array and the read register in one edge.
module sync_ram_sp #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr,
  input  logic                  en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] write,
  output logic [DATA_WIDTH-1:0] read
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic do_wr;
  logic do_rd;

  // An unknown en fails the test in if(), so X/Z behaves as disabled
  assign do_wr = en && wr;
  assign do_rd = en && !wr;

  // Storage: clear on reset, otherwise single write port
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (do_wr) begin
      mem[addr] <= write;
    end
  end

  // Read register: loads only on a read, holds otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      read <= '0;
    end else if (do_rd) begin
      read <= mem[addr];
    end
  end

  // en must be a known level whenever reset is released
  a_en_known : assert property (
    @(posedge clk) disable iff (rst) !$isunknown(en)
  );

endmodule

// File: tb/tb_sync_ram_sp.sv
// tb_sync_ram_sp: directed and random checks of sync_ram_sp
// against an array-based reference model.
module tb_sync_ram_sp;

  localparam int AW = 3;
  localparam int DW = 8;
  localparam int DEPTH = 2 ** AW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr = 1'b0;
  logic          en = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] write = '0;
  logic [DW-1:0] read;

  int vectors = 0;
  int errors = 0;

  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] exp_rd;

  sync_ram_sp #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .wr   (wr),
    .en   (en),
    .addr (addr),
    .write(write),
    .read (read)
  );

  always #5 clk = ~clk;

  // Drive one operation at negedge, let it take effect at the
  // posedge, then update the reference model. Sampling is #1 later.
  task automatic cyc(
    input logic          r,
    input logic          e,
    input logic          w,
    input logic [AW-1:0] a,
    input logic [DW-1:0] d
  );
    @(negedge clk);
    rst = r;
    en = e;
    wr = w;
    addr = a;
    write = d;
    @(posedge clk);
    #1;
    if (r) begin
      foreach (model[i]) model[i] = '0;
      exp_rd = '0;
    end else if (e && w) begin
      model[a] = d;
    end else if (e) begin
      exp_rd = model[a];
    end
  endtask

  task automatic test_reset();
    cyc(1'b1, 1'b1, 1'b1, 3'd2, 8'h77);
    cyc(1'b1, 1'b0, 1'b0, 3'd0, 8'h00);
    vectors++;
    if (read !== 8'h00) begin
      $display("FAIL reset_read got=%h exp=%h", read, 8'h00);
      errors++;
    end
  endtask

  task automatic test_fill();
    logic [AW-1:0] a_t [5];
    logic [DW-1:0] d_t [5];
    a_t = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5};
    d_t = '{8'd2, 8'd1, 8'd2, 8'd3, 8'd5};
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b1, 1'b1, a_t[i], d_t[i]);
      vectors++;
      if (read !== 8'h00) begin
        $display("FAIL fill_hold[%0d] got=%h exp=%h",
                 i, read, 8'h00);
        errors++;
      end
    end
  endtask

  task automatic test_readback();
    logic [AW-1:0] a_t [5];
    logic [DW-1:0] d_t [5];
    a_t = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5};
    d_t = '{8'd2, 8'd1, 8'd2, 8'd3, 8'd5};
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b1, 1'b0, a_t[i], 8'hEE);
      vectors++;
      if (read !== d_t[i]) begin
        $display("FAIL readback a=%0d got=%h exp=%h",
                 a_t[i], read, d_t[i]);
        errors++;
      end
    end
  endtask

  task automatic test_unwritten();
    logic [AW-1:0] a_t [3];
    a_t = '{3'd4, 3'd6, 3'd7};
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 1'b0, a_t[i], 8'h00);
      vectors++;
      if (read !== 8'h00) begin
        $display("FAIL unwritten a=%0d got=%h exp=%h",
                 a_t[i], read, 8'h00);
        errors++;
      end
    end
  endtask

  task automatic test_enable();
    cyc(1'b0, 1'b1, 1'b0, 3'd5, 8'h00);
    vectors++;
    if (read !== 8'd5) begin
      $display("FAIL en_pre got=%h exp=%h", read, 8'd5);
      errors++;
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 3'd0, 8'hFF);
      vectors++;
      if (read !== 8'd5) begin
        $display("FAIL en_gate_wr[%0d] got=%h exp=%h",
                 i, read, 8'd5);
        errors++;
      end
    end
    cyc(1'b0, 1'b0, 1'b0, 3'd3, 8'h00);
    vectors++;
    if (read !== 8'd5) begin
      $display("FAIL en_gate_rd got=%h exp=%h", read, 8'd5);
      errors++;
    end
    cyc(1'b0, 1'b1, 1'b0, 3'd0, 8'h00);
    vectors++;
    if (read !== 8'd2) begin
      $display("FAIL en_after got=%h exp=%h", read, 8'd2);
      errors++;
    end
  endtask

  task automatic test_back_to_back();
    cyc(1'b0, 1'b1, 1'b1, 3'd7, 8'hA5);
    vectors++;
    if (read !== 8'd2) begin
      $display("FAIL waw_hold got=%h exp=%h", read, 8'd2);
      errors++;
    end
    cyc(1'b0, 1'b1, 1'b1, 3'd7, 8'h3C);
    cyc(1'b0, 1'b1, 1'b0, 3'd7, 8'h00);
    vectors++;
    if (read !== 8'h3C) begin
      $display("FAIL waw_read got=%h exp=%h", read, 8'h3C);
      errors++;
    end
  endtask

  task automatic test_mid_reset();
    logic [AW-1:0] a_t [5];
    a_t = '{3'd0, 3'd1, 3'd3, 3'd5, 3'd7};
    cyc(1'b1, 1'b1, 1'b0, 3'd3, 8'h00);
    vectors++;
    if (read !== 8'h00) begin
      $display("FAIL mid_rst got=%h exp=%h", read, 8'h00);
      errors++;
    end
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b1, 1'b0, a_t[i], 8'h00);
      vectors++;
      if (read !== 8'h00) begin
        $display("FAIL mid_rst_rd a=%0d got=%h exp=%h",
                 a_t[i], read, 8'h00);
        errors++;
      end
    end
  endtask

  task automatic test_random();
    logic          r;
    logic          e;
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 39) == 0);
      e = ($urandom_range(0, 3) != 0);
      w = $urandom_range(0, 1) == 1;
      a = AW'($urandom_range(0, DEPTH - 1));
      d = DW'($urandom);
      cyc(r, e, w, a, d);
      vectors++;
      if (read !== exp_rd) begin
        $display("FAIL random[%0d] got=%h exp=%h",
                 i, read, exp_rd);
        errors++;
      end
    end
  endtask

  initial begin
    foreach (model[i]) model[i] = '0;
    exp_rd = '0;
    test_reset();
    test_fill();
    test_readback();
    test_unwritten();
    test_enable();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
